// File: rtl/wisc25_lsu_pkg.sv
// Shared definitions for the WISC-25 load/store unit: funct3 encodings,
// FSM state encoding, trap cause codes and the captured-op payload.
package wisc25_lsu_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I load funct3
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  // RV32I store funct3
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  // Op fields kept across the transaction for load extraction and writeback
  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] off;
    logic [4:0] rd;
  } lsu_op_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the execute-side, writeback-side and memory-side signals of the
// load/store unit. Names are from the unit's point of view (i_* in, o_* out).
//   slave  : the load/store unit
//   master : the environment (execute stage, writeback stage, data memory)
interface load_store_unit_if;

  logic                            i_valid;
  logic                            o_ready;
  logic                            i_load;
  logic                            i_store;
  logic [2:0]                      i_funct3;
  logic [wisc25_lsu_pkg::XLEN-1:0] i_addr;
  logic [wisc25_lsu_pkg::XLEN-1:0] i_wdata;
  logic [4:0]                      i_rd;

  logic                            o_valid;
  logic                            i_resp_ready;
  logic [wisc25_lsu_pkg::XLEN-1:0] o_rdata;
  logic [4:0]                      o_rd;
  logic                            o_trap;
  logic [1:0]                      o_cause;

  logic                            o_mem_req;
  logic                            i_mem_ready;
  logic [wisc25_lsu_pkg::XLEN-1:0] o_mem_addr;
  logic                            o_mem_ren;
  logic                            o_mem_wen;
  logic [wisc25_lsu_pkg::XLEN-1:0] o_mem_wdata;
  logic [3:0]                      o_mem_mask;
  logic                            i_mem_valid;
  logic [wisc25_lsu_pkg::XLEN-1:0] i_mem_rdata;

  modport slave (
    input  i_valid, i_load, i_store, i_funct3, i_addr, i_wdata, i_rd,
    input  i_resp_ready, i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_ready, o_valid, o_rdata, o_rd, o_trap, o_cause,
    output o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask
  );

  modport master (
    output i_valid, i_load, i_store, i_funct3, i_addr, i_wdata, i_rd,
    output i_resp_ready, i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_ready, o_valid, o_rdata, o_rd, o_trap, o_cause,
    input  o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask
  );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane logic: byte mask, store-data lane shift, load-data
// extract + extension, and misalign / illegal-funct3 checks.
//   is_load_i  : op is a load (selects which funct3 values are legal)
//   funct3_i   : RV32I load/store funct3
//   off_i      : byte offset addr[1:0]
//   wdata_i    : raw store data (rs2)
//   rdata_i    : raw memory read word
//   mask_o     : byte-lane enables
//   wdata_o    : lane-shifted store data
//   rdata_o    : extracted and extended load data
//   misalign_o : access not naturally aligned
//   illegal_o  : funct3 not a valid load/store size
module lsu_data_align
  import wisc25_lsu_pkg::*;
(
  input  logic            is_load_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      mask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [4:0]      sh_amt;
  logic [XLEN-1:0] rshift;

  assign sh_amt = {off_i, 3'b000};
  assign rshift = rdata_i >> sh_amt;

  // Size decode shared by loads and stores (funct3[2] only selects unsigned)
  always_comb begin
    mask_o     = 4'b0000;
    wdata_o    = '0;
    misalign_o = 1'b0;
    unique case (funct3_i[1:0])
      SB[1:0]: begin
        mask_o  = 4'b0001 << off_i;
        wdata_o = XLEN'(wdata_i[7:0]) << sh_amt;
      end
      SH[1:0]: begin
        mask_o     = 4'b0011 << off_i;
        wdata_o    = XLEN'(wdata_i[15:0]) << sh_amt;
        misalign_o = off_i[0];
      end
      SW[1:0]: begin
        mask_o     = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = (off_i != 2'b00);
      end
      default: ;
    endcase
  end

  // Legal funct3 sets differ: loads allow 0,1,2,4,5; stores allow 0,1,2
  always_comb begin
    illegal_o = 1'b0;
    if (is_load_i) begin
      illegal_o = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
    end else begin
      illegal_o = (funct3_i > SW);
    end
  end

  // Load extraction from the lane-aligned word
  always_comb begin
    rdata_o = '0;
    unique case (funct3_i)
      LB:      rdata_o = {{24{rshift[7]}}, rshift[7:0]};
      LH:      rdata_o = {{16{rshift[15]}}, rshift[15:0]};
      LW:      rdata_o = rshift;
      LBU:     rdata_o = XLEN'(rshift[7:0]);
      LHU:     rdata_o = XLEN'(rshift[15:0]);
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit for the WISC-25 memory stage. Accepts one op
// from execute, issues a request to a variable-latency data memory, and
// returns an extended load result or a trap to writeback.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : execute handshake (i_valid/o_ready + op fields),
//                  writeback handshake (o_valid/i_resp_ready + result),
//                  memory request/response channel
// Parameters:
//   TIMEOUT_CYCLES : cycles in REQ+WAIT before a bus-timeout trap (0 = off)
//   TIMEOUT_W      : derived counter width
module load_store_unit
  import wisc25_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  load_store_unit_if.slave bus
);

  localparam int unsigned CNT_W   = (TIMEOUT_W == 0) ? 1 : TIMEOUT_W;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  lsu_state_e      state_q;
  lsu_op_t         op_q;
  logic [CNT_W-1:0] cnt_q;

  logic            ready_q;
  logic            valid_q;
  logic [XLEN-1:0] rdata_q;
  logic [4:0]      rd_q;
  logic            trap_q;
  logic [1:0]      cause_q;

  logic            mem_req_q;
  logic            mem_ren_q;
  logic            mem_wen_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [3:0]      mem_mask_q;

  logic [2:0]      al_funct3;
  logic [1:0]      al_off;
  logic [3:0]      al_mask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_misalign;
  logic            al_illegal;
  logic            accept;
  logic            timeout_hit;

  // Live op fields feed the aligner while idle; captured ones afterwards
  assign al_funct3 = (state_q == ST_IDLE) ? bus.i_funct3   : op_q.funct3;
  assign al_off    = (state_q == ST_IDLE) ? bus.i_addr[1:0] : op_q.off;

  lsu_data_align u_align (
    .is_load_i  (bus.i_load),
    .funct3_i   (al_funct3),
    .off_i      (al_off),
    .wdata_i    (bus.i_wdata),
    .rdata_i    (bus.i_mem_rdata),
    .mask_o     (al_mask),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign),
    .illegal_o  (al_illegal)
  );

  assign accept      = bus.i_valid && (bus.i_load || bus.i_store);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_W'(TO_LAST));

  // Control FSM with all bus/result outputs held in registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      rd_q        <= '0;
      trap_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      mem_req_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= '{is_load: bus.i_load, funct3: bus.i_funct3,
                         off: bus.i_addr[1:0], rd: bus.i_rd};
            ready_q <= 1'b0;
            // Illegal funct3 takes precedence over misalignment
            if (al_illegal || al_misalign) begin
              state_q <= ST_RESP;
              valid_q <= 1'b1;
              trap_q  <= 1'b1;
              cause_q <= al_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
              rdata_q <= '0;
              rd_q    <= '0;
            end else begin
              state_q     <= ST_REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_ren_q   <= bus.i_load;
              mem_wen_q   <= !bus.i_load;
              mem_addr_q  <= {bus.i_addr[XLEN-1:2], 2'b00};
              mem_mask_q  <= al_mask;
              mem_wdata_q <= bus.i_load ? '0 : al_wdata;
            end
          end
        end

        ST_REQ: begin
          if (bus.i_mem_ready) begin
            mem_req_q <= 1'b0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            if (op_q.is_load) begin
              state_q <= ST_WAIT;
              cnt_q   <= cnt_q + CNT_W'(1);
            end else begin
              // Stores complete on acceptance
              state_q <= ST_RESP;
              valid_q <= 1'b1;
              trap_q  <= 1'b0;
              cause_q <= CAUSE_NONE;
              rdata_q <= '0;
              rd_q    <= '0;
            end
          end else if (timeout_hit) begin
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            valid_q   <= 1'b1;
            trap_q    <= 1'b1;
            cause_q   <= CAUSE_TIMEOUT;
            rdata_q   <= '0;
            rd_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT: begin
          if (bus.i_mem_valid) begin
            state_q <= ST_RESP;
            valid_q <= 1'b1;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            rdata_q <= al_rdata;
            rd_q    <= op_q.rd;
          end else if (timeout_hit) begin
            state_q <= ST_RESP;
            valid_q <= 1'b1;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
            rdata_q <= '0;
            rd_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (bus.i_resp_ready) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            rdata_q <= '0;
            rd_q    <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_rd        = rd_q;
  assign bus.o_trap      = trap_q;
  assign bus.o_cause     = cause_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_ren   = mem_ren_q;
  assign bus.o_mem_wen   = mem_wen_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_mask  = mem_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  import wisc25_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(256)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    chk("accept_ready", 32'(bus.o_ready), 32'd1);
    bus.i_valid  = 1'b1;
    bus.i_load   = ld;
    bus.i_store  = !ld;
    bus.i_funct3 = f3;
    bus.i_addr   = addr;
    bus.i_wdata  = wd;
    bus.i_rd     = rd;
    tick();
    bus.i_valid  = 1'b0;
    bus.i_load   = 1'b0;
    bus.i_store  = 1'b0;
  endtask

  task automatic release_resp();
    bus.i_resp_ready = 1'b1;
    tick();
    bus.i_resp_ready = 1'b0;
    chk("rel_ready", 32'(bus.o_ready), 32'd1);
    chk("rel_valid", 32'(bus.o_valid), 32'd0);
  endtask

  // Store with immediate memory acceptance: REQ on cycle 2, o_valid on cycle 3
  task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                           input logic [31:0] exp_wdata);
    bus.i_mem_ready = 1'b1;
    issue(1'b0, f3, addr, wd, 5'd1);
    chk("st_req",   32'(bus.o_mem_req), 32'd1);
    chk("st_wen",   32'(bus.o_mem_wen), 32'd1);
    chk("st_ren",   32'(bus.o_mem_ren), 32'd0);
    chk("st_addr",  bus.o_mem_addr, exp_addr);
    chk("st_mask",  32'(bus.o_mem_mask), 32'(exp_mask));
    chk("st_wdata", bus.o_mem_wdata, exp_wdata);
    chk("st_early_valid", 32'(bus.o_valid), 32'd0);
    tick();
    bus.i_mem_ready = 1'b0;
    chk("st_valid", 32'(bus.o_valid), 32'd1);
    chk("st_trap",  32'(bus.o_trap), 32'd0);
    chk("st_rd",    32'(bus.o_rd), 32'd0);
    chk("st_req_drop", 32'(bus.o_mem_req), 32'd0);
    release_resp();
  endtask

  // Load with immediate acceptance and data on the first WAIT cycle (4-cycle latency)
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [3:0] exp_mask,
                          input logic [31:0] exp_data);
    bus.i_mem_ready = 1'b1;
    issue(1'b1, f3, addr, 32'h0, rd);
    chk("ld_ren",  32'(bus.o_mem_ren), 32'd1);
    chk("ld_mask", 32'(bus.o_mem_mask), 32'(exp_mask));
    tick();
    bus.i_mem_ready = 1'b0;
    chk("ld_wait_valid", 32'(bus.o_valid), 32'd0);
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = rdata;
    tick();
    bus.i_mem_valid = 1'b0;
    chk("ld_valid", 32'(bus.o_valid), 32'd1);
    chk("ld_rdata", bus.o_rdata, exp_data);
    chk("ld_rd",    32'(bus.o_rd), 32'(rd));
    chk("ld_trap",  32'(bus.o_trap), 32'd0);
    release_resp();
  endtask

  // Trapping op: o_valid on cycle 2, no memory request ever
  task automatic run_trap(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [1:0] exp_cause);
    issue(ld, f3, addr, 32'h1234_5678, 5'd4);
    chk("tr_valid", 32'(bus.o_valid), 32'd1);
    chk("tr_trap",  32'(bus.o_trap), 32'd1);
    chk("tr_cause", 32'(bus.o_cause), 32'(exp_cause));
    chk("tr_req",   32'(bus.o_mem_req), 32'd0);
    chk("tr_rd",    32'(bus.o_rd), 32'd0);
    chk("tr_rdata", bus.o_rdata, 32'd0);
    release_resp();
    chk("tr_req_after", 32'(bus.o_mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.i_valid = 1'b0; bus.i_load = 1'b0; bus.i_store = 1'b0;
    bus.i_funct3 = 3'd0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0; bus.i_rd = 5'd0;
    bus.i_resp_ready = 1'b0; bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b0; bus.i_mem_rdata = 32'h0;

    // Reset values
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_req",   32'(bus.o_mem_req), 32'd0);
    chk("rst_ren",   32'(bus.o_mem_ren), 32'd0);
    chk("rst_wen",   32'(bus.o_mem_wen), 32'd0);
    chk("rst_trap",  32'(bus.o_trap), 32'd0);
    chk("rst_cause", 32'(bus.o_cause), 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_mask",  32'(bus.o_mem_mask), 32'd0);

    // i_valid with neither load nor store is ignored
    bus.i_valid = 1'b1; bus.i_addr = 32'h100;
    tick();
    bus.i_valid = 1'b0;
    chk("nop_ready", 32'(bus.o_ready), 32'd1);
    chk("nop_req",   32'(bus.o_mem_req), 32'd0);
    chk("nop_valid", 32'(bus.o_valid), 32'd0);

    // Stores
    run_store(SB, 32'h0000_2003, 32'h0000_00AB, 32'h0000_2000, 4'b1000, 32'hAB00_0000);
    run_store(SB, 32'h0000_2001, 32'h1122_3344, 32'h0000_2000, 4'b0010, 32'h0000_4400);
    run_store(SH, 32'h0000_2002, 32'h1234_BEEF, 32'h0000_2000, 4'b1100, 32'hBEEF_0000);
    run_store(SW, 32'h0000_2004, 32'hCAFE_F00D, 32'h0000_2004, 4'b1111, 32'hCAFE_F00D);

    // lh 0x1002, data after 5 WAIT cycles
    bus.i_mem_ready = 1'b1;
    issue(1'b1, LH, 32'h0000_1002, 32'h0, 5'd5);
    chk("lh_mask", 32'(bus.o_mem_mask), 32'hC);
    chk("lh_addr", bus.o_mem_addr, 32'h0000_1000);
    tick();
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lh_wait_valid", 32'(bus.o_valid), 32'd0);
      chk("lh_wait_req",   32'(bus.o_mem_req), 32'd0);
      tick();
    end
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h8001_1234;
    tick();
    bus.i_mem_valid = 1'b0;
    chk("lh_valid", 32'(bus.o_valid), 32'd1);
    chk("lh_rdata", bus.o_rdata, 32'hFFFF_8001);
    chk("lh_rd",    32'(bus.o_rd), 32'd5);
    release_resp();

    // lhu: i_mem_valid coinciding with the REQ handshake must be ignored
    bus.i_mem_ready = 1'b1;
    issue(1'b1, LHU, 32'h0000_1002, 32'h0, 5'd6);
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h7777_0000;
    tick();
    bus.i_mem_ready = 1'b0; bus.i_mem_valid = 1'b0;
    chk("lhu_early_valid", 32'(bus.o_valid), 32'd0);
    tick();
    chk("lhu_wait_valid", 32'(bus.o_valid), 32'd0);
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h8001_5678;
    tick();
    bus.i_mem_valid = 1'b0;
    chk("lhu_rdata", bus.o_rdata, 32'h0000_8001);
    chk("lhu_rd",    32'(bus.o_rd), 32'd6);
    release_resp();

    // Assorted loads
    run_load(LB,  32'h0000_1003, 5'd7,  32'h8000_0000, 4'b1000, 32'hFFFF_FF80);
    run_load(LB,  32'h0000_1001, 5'd8,  32'h0000_7F00, 4'b0010, 32'h0000_007F);
    run_load(LBU, 32'h0000_1000, 5'd9,  32'h1234_56FF, 4'b0001, 32'h0000_00FF);
    run_load(LW,  32'h0000_1000, 5'd10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    // Traps
    run_trap(1'b1, LW,   32'h0000_1001, CAUSE_MISALIGN);
    run_trap(1'b0, SH,   32'h0000_1003, CAUSE_MISALIGN);
    run_trap(1'b1, 3'd3, 32'h0000_1000, CAUSE_ILLEGAL);
    run_trap(1'b0, 3'd4, 32'h0000_1000, CAUSE_ILLEGAL);

    // Timeout: memory never accepts; 256 cycles in REQ
    bus.i_mem_ready = 1'b0;
    issue(1'b1, LW, 32'h0000_4000, 32'h0, 5'd9);
    n = 0;
    while (bus.o_mem_req && n < 400) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd256);
    chk("to_valid", 32'(bus.o_valid), 32'd1);
    chk("to_trap",  32'(bus.o_trap), 32'd1);
    chk("to_cause", 32'(bus.o_cause), 32'd3);
    chk("to_rd",    32'(bus.o_rd), 32'd0);
    release_resp();
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.i_mem_valid = 1'b0;
    chk("stray_valid", 32'(bus.o_valid), 32'd0);
    chk("stray_ready", 32'(bus.o_ready), 32'd1);
    chk("stray_rdata", bus.o_rdata, 32'd0);

    // Writeback backpressure for 4 cycles
    bus.i_mem_ready = 1'b1;
    issue(1'b1, LBU, 32'h0000_5002, 32'h0, 5'd3);
    tick();
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h00AB_0000;
    tick();
    bus.i_mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_rdata", bus.o_rdata, 32'h0000_00AB);
      chk("bp_rd",    32'(bus.o_rd), 32'd3);
      chk("bp_trap",  32'(bus.o_trap), 32'd0);
      chk("bp_ready", 32'(bus.o_ready), 32'd0);
      tick();
    end
    // Op presented during the release cycle is taken only the cycle after
    bus.i_resp_ready = 1'b1;
    bus.i_valid = 1'b1; bus.i_store = 1'b1; bus.i_funct3 = SB;
    bus.i_addr = 32'h0000_6000; bus.i_wdata = 32'h0000_0055; bus.i_rd = 5'd0;
    tick();
    bus.i_resp_ready = 1'b0;
    chk("bp_rel_ready", 32'(bus.o_ready), 32'd1);
    chk("bp_rel_req",   32'(bus.o_mem_req), 32'd0);
    tick();
    bus.i_valid = 1'b0; bus.i_store = 1'b0;
    chk("bp_next_req",   32'(bus.o_mem_req), 32'd1);
    chk("bp_next_mask",  32'(bus.o_mem_mask), 32'd1);
    chk("bp_next_wdata", bus.o_mem_wdata, 32'h0000_0055);
    bus.i_mem_ready = 1'b1;
    tick();
    bus.i_mem_ready = 1'b0;
    chk("bp_next_valid", 32'(bus.o_valid), 32'd1);
    release_resp();

    // Reset during WAIT discards the in-flight response
    bus.i_mem_ready = 1'b1;
    issue(1'b1, LW, 32'h0000_7000, 32'h0, 5'd11);
    tick();
    bus.i_mem_ready = 1'b0;
    rst = 1'b1;
    bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'h1234_5678;
    tick();
    chk("mrst_req",   32'(bus.o_mem_req), 32'd0);
    chk("mrst_valid", 32'(bus.o_valid), 32'd0);
    chk("mrst_ready", 32'(bus.o_ready), 32'd1);
    rst = 1'b0;
    bus.i_mem_valid = 1'b0;
    tick();
    chk("mrst_valid2", 32'(bus.o_valid), 32'd0);
    chk("mrst_rdata",  bus.o_rdata, 32'd0);
    run_load(LBU, 32'h0000_3001, 5'd12, 32'h0000_F000, 4'b0010, 32'h0000_00F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit that replaces the single-cycle combinational dmem path of the WISC-25 hart's memory stage.
- Accepts one memory op from execute via valid/ready and generates the word-aligned address, byte mask and lane-shifted store data.
- Talks to a realistic request/response data memory with variable latency, then returns the sign/zero-extended load result or a trap to writeback.
- Generalises the fixed one-cycle access with arbitrary memory latency, backpressure on both sides, an optional bus timeout and a trap-cause output.

Parameters:
- TIMEOUT_CYCLES, 256, cycles spent in REQ+WAIT before a bus-timeout trap; 0 disables the timeout.
- TIMEOUT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived; do not override).

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  execute presents an op
- o_ready  out  1  unit can accept an op (high only in IDLE)
- i_load  in  1  op is a load
- i_store  in  1  op is a store (never both with i_load)
- i_funct3  in  3  RV32I load/store funct3
- i_addr  in  32  byte address (ALU result)
- i_wdata  in  32  rs2 value for stores
- i_rd  in  5  destination register (carried through)
- o_valid  out  1  result available
- i_resp_ready  in  1  writeback accepts result
- o_rdata  out  32  extended load data (0 for stores and traps)
- o_rd  out  5  destination register (0 for stores and traps)
- o_trap  out  1  op trapped
- o_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout
- o_mem_req  out  1  memory request valid
- i_mem_ready  in  1  memory accepts the request this cycle
- o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_mem_ren  out  1  read request
- o_mem_wen  out  1  write request
- o_mem_wdata  out  32  lane-shifted store data
- o_mem_mask  out  4  byte-lane enables
- i_mem_valid  in  1  read data returned
- i_mem_rdata  in  32  read data word

Behaviour:
- Clock/reset: single clock i_clk; i_rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0 except o_ready=1. Counter and captured fields are cleared.
- Registered outputs: every memory-side and result-side output is driven from registers or the state.
- Memory-side exclusivity: o_mem_ren and o_mem_wen are never both high, and are 0 whenever o_mem_req=0.

State machine (IDLE, REQ, WAIT, RESP):
- IDLE:
  - Holds o_ready=1.
  - On i_valid && (i_load || i_store), captures the op and checks it.
  - Illegal funct3 (load funct3 3,6,7; store funct3 ≥3) → RESP with cause 2.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0) → RESP with cause 1.
  - Trapped ops issue no memory request. Otherwise → REQ.
  - i_valid with neither i_load nor i_store is ignored.
- REQ:
  - o_mem_req=1; addr, mask, wdata, ren and wen are held stable until i_mem_ready.
  - On the handshake: a store goes → RESP (complete on acceptance); a load goes → WAIT.
- WAIT:
  - On i_mem_valid, captures the extracted data → RESP.
  - i_mem_valid arriving in the same cycle as the REQ handshake is not accepted; the memory returns data no earlier than the next cycle.
- RESP:
  - o_valid=1 with result fields held until i_resp_ready; then → IDLE.
  - Next op is accepted no earlier than the cycle after.
- Timeout:
  - Counter is cleared on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion → RESP with cause 3 and o_mem_req dropped.
  - Completion on that same cycle wins over the timeout.
  - A stray i_mem_valid in IDLE or RESP is ignored.

Store lane rules (mask, then wdata):
- sb: mask = 4'b0001 << addr[1:0]; wdata = i_wdata[7:0] << 8·addr[1:0].
- sh: mask 4'b0011 or 4'b1100; wdata = i_wdata[15:0] << 8·addr[1:0].
- sw: mask 4'b1111; wdata unchanged.

Load rules:
- Loads use the same mask as stores of the same size.
- data = i_mem_rdata >> 8·addr[1:0].
- Extension by funct3: lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.

Latency:
- Best case store: 3 cycles, accept to o_valid.
- Best case load: 4 cycles.
- Trap: 2 cycles.

Reset mid-operation: returns to IDLE at the next edge, drops o_mem_req, and discards any in-flight response.

Decomposition:
- Shared package, wisc25_lsu_pkg:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State encoding.
  - Cause codes (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_TIMEOUT).
- Sub-module lsu_data_align: purely combinational mask/store-shift/load-extract-extend plus the misalign/illegal checks; instantiated once.

Test Plan:
- sb addr 0x2003, wdata 0x000000AB, i_mem_ready immediately → mask 4'b1000, o_mem_addr 0x2000, o_mem_wdata 0xAB000000, o_mem_wen=1; o_valid 3 cycles after accept with o_trap=0.
- lh addr 0x1002, memory returns 0x8001xxxx after 5 cycles of WAIT → mask 4'b1100, o_rdata 0xFFFF8001, o_rd=i_rd. Same op as lhu → o_rdata 0x00008001.
- lw addr 0x1001 → o_trap=1, o_cause=1, o_mem_req never asserted, o_valid 2 cycles after accept.
- Load with i_mem_ready low for 300 cycles (TIMEOUT_CYCLES=256) → o_trap=1, o_cause=3 after 256 cycles in REQ; a late i_mem_valid in IDLE has no effect.
- o_valid held with i_resp_ready low for 4 cycles → o_rdata, o_rd and o_trap stable and o_ready=0 throughout; next op is accepted the cycle after release.
- i_rst asserted during WAIT → next cycle: o_mem_req=0, o_valid=0, o_ready=1; a following lbu addr 0x3001 with rdata 0x0000F000 → o_rdata 0x000000F0.
